// File: rtl/fsk_frame_rx_if.sv
// Word delivery handshake between fsk_frame_rx (master) and the receive-side controller (slave).
interface fsk_frame_rx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              data_ready;

  modport master (output data_out, output data_valid, input data_ready);
  modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/fsk_frame_rx.sv
// FSK frame receiver: symbol-rate sampling of sig_reb, sync-word hunt, frame deserialization.
// Optional even-parity bit per word enabled by defining FSK_FRAME_RX_PARITY_EN.
module fsk_frame_rx #(
  parameter int                SYM_LEN      = 16,
  parameter int                SAMPLE_PHASE = 15,
  parameter int                SYNC_W       = 8,
  parameter logic [SYNC_W-1:0] SYNC_WORD    = 8'hA5,
  parameter int                DATA_W       = 8,
  parameter int                FRAME_LEN    = 4
) (
  input  logic           sysclk,
  input  logic           reset,
  input  logic           trans_enable,
  input  logic           sig_reb,
  fsk_frame_rx_if.master rx_if,
  output logic           frame_active,
  output logic           frame_done,
  output logic           overrun,
  output logic           parity_err
);

`ifdef FSK_FRAME_RX_PARITY_EN
  localparam int BITS_PER_WORD = DATA_W + 1;
`else
  localparam int BITS_PER_WORD = DATA_W;
`endif
  localparam int SYM_CNT_W = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
  localparam int BIT_CNT_W = $clog2(BITS_PER_WORD + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HUNT = 2'd1,
    RECV = 2'd2
  } state_e;

  state_e                 state_q;
  logic [SYM_CNT_W-1:0]   sym_cnt_q;
  logic [SYNC_W-1:0]      sync_q;
  logic [SYNC_W-1:0]      sync_d;
  logic [DATA_W-1:0]      shift_q;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic [7:0]             word_cnt_q;
  logic [DATA_W-1:0]      data_out_q;
  logic                   data_valid_q;
  logic                   frame_active_q;
  logic                   frame_done_q;
  logic                   overrun_q;
  logic                   sample_stb;
  logic                   word_full;
  logic                   last_word;
  logic                   accept;
`ifdef FSK_FRAME_RX_PARITY_EN
  logic                   par_bit_q;
  logic                   parity_err_q;
`endif

  always_comb begin
    sync_d     = {sync_q[SYNC_W-2:0], sig_reb};
    sample_stb = (sym_cnt_q == SYM_CNT_W'(SAMPLE_PHASE)) && !trans_enable;
    word_full  = (bit_cnt_q == BIT_CNT_W'(BITS_PER_WORD));
    last_word  = (word_cnt_q == 8'(FRAME_LEN - 1));
    accept     = data_valid_q && rx_if.data_ready;
  end

  // Symbol timing, sync hunt, deserializer and output handshake.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state_q        <= IDLE;
      sym_cnt_q      <= '0;
      sync_q         <= '0;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      word_cnt_q     <= 8'd0;
      data_out_q     <= '0;
      data_valid_q   <= 1'b0;
      frame_active_q <= 1'b0;
      frame_done_q   <= 1'b0;
      overrun_q      <= 1'b0;
`ifdef FSK_FRAME_RX_PARITY_EN
      par_bit_q      <= 1'b0;
      parity_err_q   <= 1'b0;
`endif
    end else if (trans_enable) begin
      // Transmit mode: abort any frame but let a pending word drain.
      state_q        <= IDLE;
      sym_cnt_q      <= '0;
      sync_q         <= '0;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      word_cnt_q     <= 8'd0;
      frame_active_q <= 1'b0;
      frame_done_q   <= 1'b0;
      overrun_q      <= 1'b0;
`ifdef FSK_FRAME_RX_PARITY_EN
      par_bit_q      <= 1'b0;
      parity_err_q   <= 1'b0;
`endif
      if (accept) begin
        data_valid_q <= 1'b0;
      end
    end else begin
      if (sym_cnt_q == SYM_CNT_W'(SYM_LEN - 1)) begin
        sym_cnt_q <= '0;
      end else begin
        sym_cnt_q <= sym_cnt_q + 1'b1;
      end
      frame_done_q <= 1'b0;
      if (accept) begin
        data_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          state_q <= HUNT;
        end
        HUNT: begin
          if (sample_stb) begin
            if (sync_d == SYNC_WORD) begin
              state_q        <= RECV;
              frame_active_q <= 1'b1;
              sync_q         <= '0;
              bit_cnt_q      <= '0;
              word_cnt_q     <= 8'd0;
            end else begin
              sync_q <= sync_d;
            end
          end
        end
        RECV: begin
          if (word_full) begin
            // A newly completed word overrides a word accepted on this same edge.
            if (!data_valid_q || rx_if.data_ready) begin
              data_out_q   <= shift_q;
              data_valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
`ifdef FSK_FRAME_RX_PARITY_EN
            if (^{shift_q, par_bit_q}) begin
              parity_err_q <= 1'b1;
            end
`endif
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            word_cnt_q <= word_cnt_q + 8'd1;
            if (last_word) begin
              frame_done_q   <= 1'b1;
              frame_active_q <= 1'b0;
              state_q        <= HUNT;
            end
          end else if (sample_stb) begin
`ifdef FSK_FRAME_RX_PARITY_EN
            if (bit_cnt_q < BIT_CNT_W'(DATA_W)) begin
              shift_q <= {shift_q[DATA_W-2:0], sig_reb};
            end else begin
              par_bit_q <= sig_reb;
            end
`else
            shift_q <= {shift_q[DATA_W-2:0], sig_reb};
`endif
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q        <= IDLE;
          frame_active_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_if.data_out   = data_out_q;
  assign rx_if.data_valid = data_valid_q;
  assign frame_active     = frame_active_q;
  assign frame_done       = frame_done_q;
  assign overrun          = overrun_q;
`ifdef FSK_FRAME_RX_PARITY_EN
  assign parity_err       = parity_err_q;
`else
  assign parity_err       = 1'b0;
`endif

endmodule

// File: doc/fsk_frame_rx.md
Name: fsk_frame_rx

Overview:
- Downstream consumer of the FSK demodulator's recovered bit stream `sig_reb`.
- Samples one bit per symbol period, hunts for a sync word, then deserializes a fixed-length frame of data words.
- Delivers each word over a valid/ready handshake to the receive-side controller.
- Symbol timing is aligned to the same `trans_enable` gating the demodulator uses, so sampling stays phase-locked to the demodulator's 16-cycle decision window.

Parameters:
- SYM_LEN, 16, sysclk cycles per symbol; must match the demodulator window.
- SAMPLE_PHASE, 15, symbol-counter value at which `sig_reb` is sampled (0..SYM_LEN-1).
- SYNC_W, 8, sync word width in bits.
- SYNC_WORD, 8'hA5, sync pattern, MSB received first.
- DATA_W, 8, data word width.
- FRAME_LEN, 4, data words per frame (1..255).

Ports:
- sysclk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- trans_enable  in  1  high = link in transmit mode; receiver held idle and all counters cleared.
- sig_reb  in  1  demodulated bit from the FSK demodulator.
- data_out  out  DATA_W  received word, MSB first on line.
- data_valid  out  1  data_out holds an unconsumed word.
- data_ready  in  1  consumer accepts the word when data_valid && data_ready.
- frame_active  out  1  high while in RECV.
- frame_done  out  1  single-cycle pulse when the last word of a frame is loaded.
- overrun  out  1  sticky; a word completed while data_valid was still high.
- parity_err  out  1  sticky parity error; see Optional Feature.

Behaviour:
- Reset (reset==0 at a clock edge), all outputs and state:
  - data_out=0, data_valid=0, frame_active=0, frame_done=0, overrun=0, parity_err=0.
  - Symbol counter=0, shift registers=0, state=IDLE.
- Symbol counter `sym_cnt`:
  - Cleared to 0 while trans_enable==1.
  - Otherwise increments each cycle and wraps SYM_LEN-1 -> 0.
  - Sample strobe = (sym_cnt==SAMPLE_PHASE) && trans_enable==0; sig_reb is captured on that edge.
- States:
  - IDLE: entered on reset or whenever trans_enable==1. Moves to HUNT on the first cycle trans_enable==0.
  - HUNT: each strobe shifts sig_reb into a SYNC_W-bit register (LSB in, older bits toward MSB). When the updated register equals SYNC_WORD, go to RECV, clear the bit and word counters, and clear the sync register. Overlapping matches are allowed; no bit-level lookback.
  - RECV: each strobe shifts sig_reb into the data shift register. After DATA_W bits, on the next edge:
    - if data_valid==0 or a handshake occurs that same cycle: load data_out and set data_valid=1;
    - else: drop the word and set overrun=1.
    - Either way, increment the word counter.
    - On the FRAME_LEN-th word, pulse frame_done for one cycle and return to HUNT.
  - frame_active=1 exactly while state==RECV.
- Handshake:
  - data_valid falls the cycle after data_valid && data_ready.
  - Load and accept in the same cycle: the new word wins and data_valid stays 1.
  - data_out is stable while data_valid==1 and is not accepted.
- Latency: data_valid rises one sysclk after the strobe that captured the word's last bit.
- trans_enable rising mid-frame:
  - Abort to IDLE next edge; partial word discarded; frame_done not pulsed.
  - A pending data_valid/data_out is kept until accepted.
  - overrun and parity_err clear on trans_enable==1.
- Reset mid-operation: immediate return to reset values on that edge, including any pending word.
- Counters: bit counter ceil(log2(DATA_W+1)) bits; word counter 8 bits; no wrap beyond FRAME_LEN.

Optional Feature:
- Macro: FSK_FRAME_RX_PARITY_EN.
- Defined:
  - Each data word is followed by one even-parity bit, sampled on the next strobe.
  - The word completes after DATA_W+1 bits.
  - On mismatch, the word is still delivered and parity_err is set (sticky until reset or trans_enable).
- Undefined: no parity bit is expected; parity_err is tied to 0.

Test Plan:
- Reset then release, trans_enable=0, idle sig_reb=0 for 200 cycles -> state HUNT, data_valid=0, frame_active=0, overrun=0.
- Send bits A5 then 3C,81,FF,00, each bit held 16 cycles, data_ready=1 -> four words 8'h3C,8'h81,8'hFF,8'h00, each with data_valid rising 1 cycle after its 8th strobe; frame_done pulses once with the last word; then back to HUNT.
- Preamble 1010_1010 followed by A5 -> sync detected only after the A5, first word correct; no false lock on the preamble.
- Same frame with data_ready=0 throughout -> data_out=8'h3C held, overrun=1 after the second word, later words dropped.
- trans_enable pulsed high for 5 cycles after 3 bits of word 2 -> IDLE, frame_active=0, no frame_done; relock on next A5, frame decoded correctly.
- With FSK_FRAME_RX_PARITY_EN: word 8'h81 followed by parity bit 1 -> data_out=8'h81 and parity_err=1; with correct parity bit 0 -> parity_err stays 0.
